// File: rtl/grayscale_row_sequencer.sv
// Frame controller for the row-parallel grayscale converter: fetches RGB rows,
// holds each row for the converter's fixed latency, and writes gray rows with valid/ready.
module grayscale_row_sequencer #(
    parameter int unsigned ROWS     = 256,
    parameter int unsigned COLS     = 256,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CONV_LAT = 1,
    parameter int unsigned AW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    rd_req,
    output logic [AW-1:0]           rd_addr,
    input  logic                    rd_valid,
    input  logic [COLS*WIDTH*3-1:0] rd_data,
    output logic [COLS*WIDTH*3-1:0] conv_row_in,
    input  logic [COLS*WIDTH-1:0]   conv_row_out,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic [AW-1:0]           wr_addr,
    output logic [COLS*WIDTH-1:0]   wr_data
);

    localparam int unsigned LW = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;
    localparam logic [AW-1:0] LAST_ROW = AW'(ROWS - 1);
    localparam logic [LW-1:0] LAST_LAT = LW'(CONV_LAT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CONV,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] row_q, row_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          load_row;
    logic          load_wr;

    // Next-state logic; abort outranks every other event once a frame is running
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        lat_d    = lat_q;
        load_row = 1'b0;
        load_wr  = 1'b0;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            row_d   = '0;
            lat_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_d = ST_FETCH;
                        row_d   = '0;
                    end
                end
                ST_FETCH: begin
                    if (rd_valid) begin
                        load_row = 1'b1;
                        lat_d    = '0;
                        state_d  = ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (lat_q == LAST_LAT) begin
                        load_wr = 1'b1;
                        state_d = ST_WRITE;
                    end else begin
                        lat_d = lat_q + LW'(1);
                    end
                end
                ST_WRITE: begin
                    if (wr_ready) begin
                        if (row_q == LAST_ROW) begin
                            state_d = ST_DONE;
                        end else begin
                            row_d   = row_q + AW'(1);
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                    lat_d   = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs derived from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            lat_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rd_req      <= 1'b0;
            wr_valid    <= 1'b0;
            rd_addr     <= '0;
            wr_addr     <= '0;
            conv_row_in <= '0;
            wr_data     <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            lat_q    <= lat_d;
            busy     <= (state_d != ST_IDLE);
            done     <= (state_d == ST_DONE);
            rd_req   <= (state_d == ST_FETCH);
            wr_valid <= (state_d == ST_WRITE);
            rd_addr  <= row_d;
            if (load_row) begin
                conv_row_in <= rd_data;
            end
            if (load_wr) begin
                wr_data <= conv_row_out;
                wr_addr <= row_q;
            end
        end
    end

endmodule

// File: tb/tb_grayscale_row_sequencer.sv
// Directed bench: a 4-row frame with wait states, stray start/rd_valid, abort and
// mid-frame reset, plus a single-row instance with a one-cycle converter.
module tb_grayscale_row_sequencer;

    logic clk;
    logic rst;

    // 4-row, CONV_LAT=2 instance
    logic        start, abort, busy, done, rd_req, rd_valid, wr_valid, wr_ready;
    logic [1:0]  rd_addr, wr_addr;
    logic [95:0] rd_data, conv_row_in;
    logic [31:0] conv_row_out, wr_data;

    // 1-row, CONV_LAT=1 instance
    logic        start1, abort1, busy1, done1, rd_req1, rd_valid1, wr_valid1, wr_ready1;
    logic [0:0]  rd_addr1, wr_addr1;
    logic [95:0] rd_data1, conv_row_in1;
    logic [31:0] conv_row_out1, wr_data1;

    int checks = 0;
    int errors = 0;

    // Source/sink knobs and monitor log
    int   src_delay [4];
    int   snk_delay [4];
    logic extra_valid;
    logic log_clr;
    int   cyc = 0;
    int   wr_n, fetch_cnt, done_cnt, overlap_cnt, conv_bad, stable_bad;
    int   rd_rise_cyc, done_cyc;
    int   req_cnt [4];
    int   wv_cnt  [4];
    logic [1:0]  log_addr [8];
    logic [31:0] log_data [8];
    int          log_cyc  [8];

    grayscale_row_sequencer #(.ROWS(4), .COLS(4), .WIDTH(8), .CONV_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
        .conv_row_in(conv_row_in), .conv_row_out(conv_row_out),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    grayscale_row_sequencer #(.ROWS(1), .COLS(4), .WIDTH(8), .CONV_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1), .busy(busy1), .done(done1),
        .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_valid(rd_valid1), .rd_data(rd_data1),
        .conv_row_in(conv_row_in1), .conv_row_out(conv_row_out1),
        .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_addr(wr_addr1), .wr_data(wr_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] row_rgb(input int r);
        logic [95:0] v;
        for (int p = 0; p < 4; p++) begin
            v[p*24+16 +: 8] = 8'(r * 40 + p * 7 + 3);
            v[p*24+8  +: 8] = 8'(r * 13 + p * 29 + 100);
            v[p*24    +: 8] = 8'(r * 71 + p * 3 + 50);
        end
        return v;
    endfunction

    function automatic logic [31:0] gray_row(input logic [95:0] v);
        logic [31:0] g;
        logic [7:0]  rr, gg, bb;
        for (int p = 0; p < 4; p++) begin
            rr = v[p*24+16 +: 8];
            gg = v[p*24+8  +: 8];
            bb = v[p*24    +: 8];
            g[p*8 +: 8] = (rr >> 2) + (gg >> 1) + (bb >> 2);
        end
        return g;
    endfunction

    // Converter models: one register stage for the 4-row unit, combinational for the 1-row unit
    always @(posedge clk) conv_row_out <= gray_row(conv_row_in);
    assign conv_row_out1 = gray_row(conv_row_in1);

    always @(posedge clk) cyc <= cyc + 1;

    // Row source and row sink, driven mid-cycle
    initial begin
        int req_age = 0;
        int wr_age  = 0;
        rd_valid  = 1'b0;
        wr_ready  = 1'b0;
        rd_data   = '0;
        rd_valid1 = 1'b0;
        rd_data1  = '0;
        forever begin
            @(posedge clk);
            #2;
            req_age  = rd_req ? req_age + 1 : 0;
            wr_age   = wr_valid ? wr_age + 1 : 0;
            rd_valid = (rd_req && (req_age > src_delay[rd_addr])) || extra_valid;
            rd_data  = rd_req ? row_rgb(int'(rd_addr)) : {12{8'hA5}};
            wr_ready = wr_valid && (wr_age > snk_delay[wr_addr]);
            rd_valid1 = rd_req1;
            rd_data1  = rd_req1 ? row_rgb(0) : {12{8'h5A}};
        end
    end

    // Monitor: logs handshakes and protocol properties of the 4-row unit
    initial begin
        logic        rd_prev = 1'b0, wv_prev = 1'b0, hs_prev = 1'b0, seen = 1'b0;
        logic [31:0] wd_prev = '0;
        logic [1:0]  wa_prev = '0;
        forever begin
            @(posedge clk);
            #3;
            if (log_clr) begin
                wr_n = 0; fetch_cnt = 0; done_cnt = 0; overlap_cnt = 0;
                conv_bad = 0; stable_bad = 0; rd_rise_cyc = -1; done_cyc = -1; seen = 1'b0;
                for (int i = 0; i < 4; i++) begin req_cnt[i] = 0; wv_cnt[i] = 0; end
                for (int i = 0; i < 8; i++) begin log_addr[i] = 'x; log_data[i] = 'x; log_cyc[i] = 0; end
            end else if (rst) begin
                if (rd_req && !rd_prev && !seen) begin rd_rise_cyc = cyc; seen = 1'b1; end
                if (rd_req) req_cnt[rd_addr]++;
                if (wr_valid) wv_cnt[wr_addr]++;
                if (rd_req && rd_valid) fetch_cnt++;
                if (rd_req && wr_valid) overlap_cnt++;
                if (wr_valid && (conv_row_in !== row_rgb(int'(wr_addr)))) conv_bad++;
                if (wr_valid && wv_prev && !hs_prev && ((wr_data !== wd_prev) || (wr_addr !== wa_prev)))
                    stable_bad++;
                if (wr_valid && wr_ready && !abort) begin
                    if (wr_n < 8) begin
                        log_addr[wr_n] = wr_addr;
                        log_data[wr_n] = wr_data;
                        log_cyc[wr_n]  = cyc;
                    end
                    wr_n++;
                end
                if (done) begin done_cnt++; done_cyc = cyc; end
            end
            rd_prev = rd_req;
            wv_prev = wr_valid;
            hs_prev = wr_valid && wr_ready;
            wd_prev = wr_data;
            wa_prev = wr_addr;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while ((done !== 1'b1) && (n < budget)) begin
            tick();
            n++;
        end
        chk(tag, 128'(done), 128'(1));
        tick();
        chk({tag, "_done_drop"}, 128'(done), 128'(0));
        chk({tag, "_busy_drop"}, 128'(busy), 128'(0));
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_writes"}, 128'(wr_n), 128'(4));
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_wr_addr%0d", tag, i), 128'(log_addr[i]), 128'(i));
            chk($sformatf("%s_wr_data%0d", tag, i), 128'(log_data[i]), 128'(gray_row(row_rgb(i))));
        end
        chk({tag, "_done_cnt"}, 128'(done_cnt), 128'(1));
        chk({tag, "_overlap"}, 128'(overlap_cnt), 128'(0));
        chk({tag, "_conv_hold"}, 128'(conv_bad), 128'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; extra_valid = 1'b0; log_clr = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; wr_ready1 = 1'b1;
        for (int i = 0; i < 4; i++) begin src_delay[i] = 0; snk_delay[i] = 0; end
        #3 rst = 1'b0;
        #1;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_rd_req", 128'(rd_req), 128'(0));
        chk("rst_wr_valid", 128'(wr_valid), 128'(0));
        chk("rst_rd_addr", 128'(rd_addr), 128'(0));
        chk("rst_wr_addr", 128'(wr_addr), 128'(0));
        chk("rst_conv_row_in", 128'(conv_row_in), 128'(0));
        chk("rst_wr_data", 128'(wr_data), 128'(0));
        tick();
        rst = 1'b1;
        tick();
        clear_log();

        // Zero-wait frame: 4 writes every 4 cycles, done 16 cycles after first fetch
        pulse_start();
        chk("f1_rd_req", 128'(rd_req), 128'(1));
        chk("f1_rd_addr", 128'(rd_addr), 128'(0));
        chk("f1_busy", 128'(busy), 128'(1));
        wait_done("f1_done", 100);
        check_frame("f1");
        for (int i = 1; i < 4; i++)
            chk($sformatf("f1_spacing%0d", i), 128'(log_cyc[i] - log_cyc[i-1]), 128'(4));
        chk("f1_first_write", 128'(log_cyc[0] - rd_rise_cyc), 128'(3));
        chk("f1_done_time", 128'(done_cyc - rd_rise_cyc), 128'(16));

        // Source stalls 3 cycles on row 1, sink stalls 5 cycles on row 2
        clear_log();
        src_delay[1] = 3;
        snk_delay[2] = 5;
        pulse_start();
        wait_done("f2_done", 200);
        check_frame("f2");
        chk("f2_req_row0", 128'(req_cnt[0]), 128'(1));
        chk("f2_req_row1", 128'(req_cnt[1]), 128'(4));
        chk("f2_wv_row2", 128'(wv_cnt[2]), 128'(6));
        chk("f2_wv_row3", 128'(wv_cnt[3]), 128'(1));
        chk("f2_stable", 128'(stable_bad), 128'(0));
        src_delay[1] = 0;
        snk_delay[2] = 0;

        // Stray start during row 2 and stray rd_valid during CONV
        clear_log();
        pulse_start();
        for (int i = 0; i < 100 && !(rd_req && rd_addr == 2'd2); i++) tick();
        chk("f3_reach_row2", 128'(rd_req && rd_addr == 2'd2), 128'(1));
        pulse_start();
        for (int i = 0; i < 100 && !(busy && !rd_req && !wr_valid && !done); i++) tick();
        chk("f3_reach_conv", 128'(busy && !rd_req && !wr_valid && !done), 128'(1));
        extra_valid = 1'b1;
        tick();
        extra_valid = 1'b0;
        wait_done("f3_done", 100);
        check_frame("f3");
        chk("f3_fetches", 128'(fetch_cnt), 128'(4));
        tick(); tick(); tick();
        chk("f3_no_restart", 128'({busy, rd_req}), 128'(0));

        // Abort in WRITE of row 1 coinciding with wr_ready
        clear_log();
        pulse_start();
        for (int i = 0; i < 100 && !(wr_valid && wr_addr == 2'd1); i++) tick();
        chk("f4_reach_write1", 128'(wr_valid && wr_addr == 2'd1), 128'(1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("f4_busy", 128'(busy), 128'(0));
        chk("f4_wr_valid", 128'(wr_valid), 128'(0));
        chk("f4_rd_req", 128'(rd_req), 128'(0));
        tick(); tick(); tick();
        chk("f4_no_done", 128'(done_cnt), 128'(0));
        chk("f4_idle", 128'(busy), 128'(0));
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        chk("f4_abort_start_idle", 128'({busy, rd_req}), 128'(0));
        clear_log();
        pulse_start();
        chk("f4_restart_req", 128'(rd_req), 128'(1));
        chk("f4_restart_addr", 128'(rd_addr), 128'(0));
        wait_done("f4_done", 100);
        check_frame("f4");

        // Asynchronous reset mid-CONV of row 2, then a clean frame
        clear_log();
        pulse_start();
        for (int i = 0; i < 100 && !(busy && !rd_req && !wr_valid && rd_addr == 2'd2); i++) tick();
        chk("f5_reach_conv2", 128'(busy && !rd_req && !wr_valid && rd_addr == 2'd2), 128'(1));
        #1 rst = 1'b0;
        #1;
        chk("f5_busy", 128'(busy), 128'(0));
        chk("f5_outs", 128'({done, rd_req, wr_valid}), 128'(0));
        chk("f5_addrs", 128'({rd_addr, wr_addr}), 128'(0));
        chk("f5_wr_data", 128'(wr_data), 128'(0));
        chk("f5_conv_row_in", 128'(conv_row_in), 128'(0));
        tick();
        rst = 1'b1;
        tick();
        clear_log();
        pulse_start();
        wait_done("f5_done", 100);
        check_frame("f5");

        // Single-row instance, one-cycle converter
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("s1_fetch", 128'({rd_req1, rd_addr1, busy1}), 128'(3'b101));
        tick();
        chk("s1_conv", 128'({rd_req1, wr_valid1, busy1}), 128'(3'b001));
        tick();
        chk("s1_write", 128'({wr_valid1, wr_addr1}), 128'(2'b10));
        chk("s1_wr_data", 128'(wr_data1), 128'(gray_row(row_rgb(0))));
        tick();
        chk("s1_done", 128'({done1, busy1, wr_valid1}), 128'(3'b110));
        tick();
        chk("s1_idle", 128'({done1, busy1}), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
